traffic_light_seq: RTL and testbench



---
 rtl/traffic_light_seq.sv | 117 +++++++++++
 tb/tb_traffic_light_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_seq.sv
// traffic_light_seq: four-phase traffic-light sequencer with per-phase dwell
// timer, tick enable and a sticky pedestrian request that shortens GREEN.
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          tick enable; counter and FSM advance only when 1
//   ped_req     pedestrian request (pulse allowed)
//   light       registered lamp word {red, amber, green}
//   phase       registered state code
//   walk        registered pedestrian walk lamp (1 only in RED)
//   ped_pending registered latched, not-yet-served request
module traffic_light_seq #(
  parameter int CW        = 5,
  parameter int RED_T     = 8,
  parameter int RA_T      = 2,
  parameter int GREEN_T   = 10,
  parameter int GREEN_MIN = 3,
  parameter int AMBER_T   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ped_req,
  output logic [2:0] light,
  output logic [1:0] phase,
  output logic       walk,
  output logic       ped_pending
);

  typedef enum logic [1:0] {
    RED       = 2'd0,
    RED_AMBER = 2'd1,
    GREEN     = 2'd2,
    AMBER     = 2'd3
  } state_t;

  localparam int CW1 = CW + 1;
  localparam logic [CW:0] RED_L   = CW1'(RED_T);
  localparam logic [CW:0] RA_L    = CW1'(RA_T);
  localparam logic [CW:0] GREEN_L = CW1'(GREEN_T);
  localparam logic [CW:0] GMIN_L  = CW1'(GREEN_MIN);
  localparam logic [CW:0] AMBER_L = CW1'(AMBER_T);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW:0]   cnt_p1;
  logic          last;
  logic          pend_n;
  logic [2:0]    light_n;
  logic          walk_n;

  // Dwell limits are compared against count+1 in one extra bit, so the
  // "count >= GREEN_MIN-1" test never degenerates into a compare with zero.
  always_comb begin
    cnt_p1  = {1'b0, cnt} + 1'b1;
    last    = 1'b0;
    state_n = state;
    cnt_n   = cnt;
    case (state)
      RED:       last = (cnt_p1 == RED_L);
      RED_AMBER: last = (cnt_p1 == RA_L);
      GREEN:     last = (cnt_p1 == GREEN_L) || (ped_pending && (cnt_p1 >= GMIN_L));
      AMBER:     last = (cnt_p1 == AMBER_L);
      default:   last = 1'b0;
    endcase

    if (en) begin
      if (last) begin
        cnt_n = '0;
        case (state)
          RED:       state_n = RED_AMBER;
          RED_AMBER: state_n = GREEN;
          GREEN:     state_n = AMBER;
          AMBER:     state_n = RED;
          default:   state_n = RED;
        endcase
      end else begin
        cnt_n = cnt_p1[CW-1:0];
      end
    end

    // A new request on the RED-entry edge wins over the clear.
    if (ped_req)
      pend_n = 1'b1;
    else if (en && last && (state == AMBER))
      pend_n = 1'b0;
    else
      pend_n = ped_pending;

    case (state_n)
      RED:       light_n = 3'b100;
      RED_AMBER: light_n = 3'b110;
      GREEN:     light_n = 3'b001;
      AMBER:     light_n = 3'b010;
      default:   light_n = 3'b100;
    endcase
    walk_n = (state_n == RED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RED;
      cnt         <= '0;
      light       <= 3'b100;
      phase       <= 2'd0;
      walk        <= 1'b1;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      light       <= light_n;
      phase       <= state_n;
      walk        <= walk_n;
      ped_pending <= pend_n;
    end
  end

endmodule

// File: tb/tb_traffic_light_seq.sv
// Directed self-checking bench for traffic_light_seq: default-parameter
// instance plus a second instance with all dwell times set to 1.
module tb_traffic_light_seq;

  logic       clk;
  logic       rst_n, en, ped_req;
  logic [2:0] light;
  logic [1:0] phase;
  logic       walk, ped_pending;

  logic       rst2, en2, ped2;
  logic [2:0] light2;
  logic [1:0] phase2;
  logic       walk2, pend2;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_light_seq u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ped_req(ped_req),
    .light(light), .phase(phase), .walk(walk), .ped_pending(ped_pending)
  );

  traffic_light_seq #(
    .RED_T(1), .RA_T(1), .GREEN_T(1), .GREEN_MIN(1), .AMBER_T(1)
  ) u_fast (
    .clk(clk), .rst_n(rst2), .en(en2), .ped_req(ped2),
    .light(light2), .phase(phase2), .walk(walk2), .ped_pending(pend2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected phase after t enabled ticks from reset, default timing 8/2/10/3.
  function automatic logic [1:0] exp_phase(input int t);
    int m;
    m = t % 23;
    if (m < 8)       return 2'd0;
    else if (m < 10) return 2'd1;
    else if (m < 20) return 2'd2;
    else             return 2'd3;
  endfunction

  function automatic logic [2:0] lamp(input logic [1:0] p);
    case (p)
      2'd0: return 3'b100;
      2'd1: return 3'b110;
      2'd2: return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge: release lands between edges.
  task automatic do_reset();
    rst_n   = 1'b0;
    en      = 1'b0;
    ped_req = 1'b0;
    #2;
    rst_n   = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; ped_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({phase, light, walk, ped_pending} !== {2'd0, 3'b100, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got phase=%0d light=%b walk=%b pend=%b, want 0 100 1 0",
               phase, light, walk, ped_pending);
    end
    en = 1'b1; ped_req = 1'b1;
    step(); step();
    n_checks++;
    if ({phase, light, walk, ped_pending} !== {2'd0, 3'b100, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_held: got phase=%0d light=%b walk=%b pend=%b, want 0 100 1 0",
               phase, light, walk, ped_pending);
    end
  endtask

  task automatic test_nominal();
    logic [1:0] ep;
    do_reset();
    en = 1'b1;
    for (int t = 1; t <= 46; t++) begin
      step();
      ep = exp_phase(t);
      n_checks++;
      if ({phase, light, walk} !== {ep, lamp(ep), ep == 2'd0}) begin
        n_fail++;
        $display("FAIL nominal t=%0d: got phase=%0d light=%b walk=%b, want phase=%0d light=%b walk=%b",
                 t, phase, light, walk, ep, lamp(ep), ep == 2'd0);
      end
    end
  endtask

  task automatic test_enable_toggle();
    logic [1:0] ep;
    int ticks;
    step();
    do_reset();
    ticks = 0;
    for (int k = 0; k < 46; k++) begin
      en = (k % 2 == 0);
      step();
      if (en) ticks++;
      ep = exp_phase(ticks);
      n_checks++;
      if ({phase, light, walk} !== {ep, lamp(ep), ep == 2'd0}) begin
        n_fail++;
        $display("FAIL en_toggle k=%0d: got phase=%0d light=%b walk=%b, want phase=%0d light=%b walk=%b",
                 k, phase, light, walk, ep, lamp(ep), ep == 2'd0);
      end
    end
  endtask

  task automatic test_ped_red_amber();
    logic [1:0] ep;
    logic       epend;
    step();
    do_reset();
    en = 1'b1;
    repeat (8) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    n_checks++;
    if ({phase, ped_pending} !== {2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL ped_ra_set: got phase=%0d pend=%b, want 1 1", phase, ped_pending);
    end
    // GREEN for ticks 10-12, AMBER 13-15, RED at 16 with request served.
    for (int t = 10; t <= 16; t++) begin
      step();
      ep    = (t <= 12) ? 2'd2 : (t <= 15) ? 2'd3 : 2'd0;
      epend = (t < 16);
      n_checks++;
      if ({phase, light, ped_pending} !== {ep, lamp(ep), epend}) begin
        n_fail++;
        $display("FAIL ped_ra t=%0d: got phase=%0d light=%b pend=%b, want phase=%0d light=%b pend=%b",
                 t, phase, light, ped_pending, ep, lamp(ep), epend);
      end
    end
  endtask

  task automatic test_ped_green7();
    step();
    do_reset();
    en = 1'b1;
    repeat (16) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    n_checks++;
    if ({phase, ped_pending} !== {2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL ped_g7_set: got phase=%0d pend=%b, want 2 1", phase, ped_pending);
    end
    for (int t = 18; t <= 20; t++) begin
      step();
      n_checks++;
      if ({phase, light} !== {2'd3, 3'b010}) begin
        n_fail++;
        $display("FAIL ped_g7_amber t=%0d: got phase=%0d light=%b, want 3 010", t, phase, light);
      end
    end
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    for (int t = 21; t <= 28; t++) begin
      if (t > 21) step();
      n_checks++;
      if ({phase, walk, ped_pending} !== {2'd0, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL ped_g7_red t=%0d: got phase=%0d walk=%b pend=%b, want 0 1 1",
                 t, phase, walk, ped_pending);
      end
    end
    step();
    n_checks++;
    if ({phase, ped_pending} !== {2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL ped_g7_ra: got phase=%0d pend=%b, want 1 1", phase, ped_pending);
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] ep;
    step();
    do_reset();
    en = 1'b1;
    repeat (10) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    step();
    n_checks++;
    if ({phase, ped_pending} !== {2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL arst_pre: got phase=%0d pend=%b, want 2 1", phase, ped_pending);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({phase, light, walk, ped_pending} !== {2'd0, 3'b100, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL arst_mid: got phase=%0d light=%b walk=%b pend=%b, want 0 100 1 0",
               phase, light, walk, ped_pending);
    end
    #1 rst_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      step();
      ep = exp_phase(t);
      n_checks++;
      if ({phase, light} !== {ep, lamp(ep)}) begin
        n_fail++;
        $display("FAIL arst_after t=%0d: got phase=%0d light=%b, want phase=%0d light=%b",
                 t, phase, light, ep, lamp(ep));
      end
    end
  endtask

  task automatic test_param_override();
    logic [1:0] ep;
    n_checks++;
    if ({phase2, light2, walk2, pend2} !== {2'd0, 3'b100, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL fast_reset: got phase=%0d light=%b walk=%b pend=%b, want 0 100 1 0",
               phase2, light2, walk2, pend2);
    end
    rst2 = 1'b1;
    en2  = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      ped2 = (t == 3 || t == 6);
      step();
      ep = 2'(t % 4);
      n_checks++;
      if ({phase2, light2, walk2} !== {ep, lamp(ep), ep == 2'd0}) begin
        n_fail++;
        $display("FAIL fast t=%0d: got phase=%0d light=%b walk=%b, want phase=%0d light=%b walk=%b",
                 t, phase2, light2, walk2, ep, lamp(ep), ep == 2'd0);
      end
    end
    ped2 = 1'b0;
  endtask

  initial begin
    rst2 = 1'b0; en2 = 1'b0; ped2 = 1'b0;
    test_reset();
    test_nominal();
    test_enable_toggle();
    test_ped_red_amber();
    test_ped_green7();
    test_async_reset();
    test_param_override();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
